// File: rtl/axis_pkt_framer_pkg.sv
// Shared types and helpers for the AXI4-Stream packet framer and its skid buffer.
package axis_pkt_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PAD  = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // tkeep constants are built 64 bits wide and narrowed by the user to DWIDTH/8.
  function automatic logic [63:0] keep_all(input int dwidth);
    return (64'd1 << (dwidth / 8)) - 64'd1;
  endfunction

  localparam logic [63:0] KEEP_NULL64 = 64'd0;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer: full throughput, 1-cycle latency, all outputs from flops.
module axis_skid_buffer #(
  parameter int W = 19
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         ready_q, ready_d;
  logic         wr;

  assign wr = in_valid_i && ready_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready_i) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = wr;
        if (wr) out_data_d = in_data_i;
      end
    end else if (wr) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
    // Ready is registered so it stays low throughout reset and is glitch-free.
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/axis_pkt_framer.sv
// Groups bare AXI4-Stream beats into fixed-length packets with tlast, padding stalled partials.
module axis_pkt_framer
  import axis_pkt_framer_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int PKT_LEN   = 8,
  parameter int TIMEOUT   = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  s_din_tvalid,
  output logic                  s_din_tready,
  input  logic [DWIDTH-1:0]     s_din_tdata,
  output logic                  m_dout_tvalid,
  input  logic                  m_dout_tready,
  output logic [DWIDTH-1:0]     m_dout_tdata,
  output logic [DWIDTH/8-1:0]   m_dout_tkeep,
  output logic                  m_dout_tlast,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  pad_count
);

  localparam int KW = DWIDTH / 8;
  localparam int PW = DWIDTH + KW + 1;
  localparam int BW = (clog2(PKT_LEN) < 1) ? 1 : clog2(PKT_LEN);
  localparam int TW = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [KW-1:0] KEEP_ALL  = KW'(keep_all(DWIDTH));
  localparam logic [KW-1:0] KEEP_NULL = KW'(KEEP_NULL64);

  state_e               state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0] pad_cnt_q, pad_cnt_d;

  logic          skid_ready, wr_valid, wr_fire, is_last, out_hs;
  logic [PW-1:0] wr_data, out_data;

  assign is_last      = (beat_q == BW'(PKT_LEN - 1));
  assign wr_valid     = (state_q == ST_PAD) || s_din_tvalid;
  assign wr_fire      = wr_valid && skid_ready;
  assign s_din_tready = (state_q != ST_PAD) && skid_ready;
  assign wr_data      = (state_q == ST_PAD) ? {KEEP_NULL, is_last, {DWIDTH{1'b0}}}
                                            : {KEEP_ALL, is_last, s_din_tdata};
  assign out_hs       = m_dout_tvalid && m_dout_tready;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    timer_d   = timer_q;
    pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(out_hs && m_dout_tlast);
    pad_cnt_d = pad_cnt_q + CNT_WIDTH'(wr_fire && (state_q == ST_PAD));
    if (wr_fire) beat_d = is_last ? '0 : beat_q + BW'(1);
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (wr_fire && !is_last) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (wr_fire) begin
          timer_d = '0;
          if (is_last) state_d = ST_IDLE;
        // A full skid buffer is output backpressure, not an input stall.
        end else if (skid_ready && (TIMEOUT != 0)) begin
          if (timer_q == TW'(TIMEOUT - 1)) begin
            timer_d = '0;
            state_d = ST_PAD;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      ST_PAD: begin
        if (wr_fire && is_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      timer_q   <= '0;
      pkt_cnt_q <= '0;
      pad_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      timer_q   <= timer_d;
      pkt_cnt_q <= pkt_cnt_d;
      pad_cnt_q <= pad_cnt_d;
    end
  end

  axis_skid_buffer #(
    .W(PW)
  ) u_skid (
    .clk_i      (ap_clk),
    .rst_ni     (ap_rst_n),
    .in_valid_i (wr_valid),
    .in_ready_o (skid_ready),
    .in_data_i  (wr_data),
    .out_valid_o(m_dout_tvalid),
    .out_ready_i(m_dout_tready),
    .out_data_o (out_data)
  );

  assign m_dout_tdata = out_data[DWIDTH-1:0];
  assign m_dout_tlast = out_data[DWIDTH];
  assign m_dout_tkeep = out_data[PW-1:DWIDTH+1];
  assign pkt_count    = pkt_cnt_q;
  assign pad_count    = pad_cnt_q;

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Directed bench for axis_pkt_framer: default instance plus a PKT_LEN=1 / TIMEOUT=0 instance.
module tb_axis_pkt_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        s_valid, s_ready, m_valid, m_ready, m_last;
  logic [15:0] s_data, m_data;
  logic [1:0]  m_keep;
  logic [31:0] pkt_cnt, pad_cnt;

  logic        s1_valid, s1_ready, m1_valid, m1_ready, m1_last;
  logic [15:0] s1_data, m1_data;
  logic [1:0]  m1_keep;
  logic [31:0] pkt1_cnt, pad1_cnt;

  axis_pkt_framer #(.DWIDTH(16), .PKT_LEN(8), .TIMEOUT(64), .CNT_WIDTH(32)) u0 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_din_tvalid(s_valid), .s_din_tready(s_ready), .s_din_tdata(s_data),
    .m_dout_tvalid(m_valid), .m_dout_tready(m_ready), .m_dout_tdata(m_data),
    .m_dout_tkeep(m_keep), .m_dout_tlast(m_last),
    .pkt_count(pkt_cnt), .pad_count(pad_cnt)
  );

  axis_pkt_framer #(.DWIDTH(16), .PKT_LEN(1), .TIMEOUT(0), .CNT_WIDTH(32)) u1 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_din_tvalid(s1_valid), .s_din_tready(s1_ready), .s_din_tdata(s1_data),
    .m_dout_tvalid(m1_valid), .m_dout_tready(m1_ready), .m_dout_tdata(m1_data),
    .m_dout_tkeep(m1_keep), .m_dout_tlast(m1_last),
    .pkt_count(pkt1_cnt), .pad_count(pad1_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Expected output beats {tlast, tkeep, tdata} for u0, in order.
  logic [18:0] exp_q[$];
  int          tb_idx = 0;
  int          popped = 0;
  bit          rand_mode = 1'b0;

  function automatic void push(input logic [15:0] d, input logic [1:0] k);
    exp_q.push_back({(tb_idx == 7), k, d});
    tb_idx = (tb_idx == 7) ? 0 : tb_idx + 1;
  endfunction

  // Output monitor on the falling edge: handshakes, ordering, stall stability.
  initial begin
    logic [18:0] cur, prev_beat, e;
    bit prev_stall;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      cur = {m_last, m_keep, m_data};
      if (rst_n) begin
        if (prev_stall) check("stall_hold", 64'({m_valid, cur}), 64'({1'b1, prev_beat}));
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", 64'(exp_q.size()), 64'(1));
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'(cur), 64'(e));
            popped++;
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_beat  = cur;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d);
    bit acc;
    acc = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 500 && !acc; i++) begin
      acc = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    if (acc) push(d, 2'b11);
    else check("send_timeout", 64'(acc), 64'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  // Asynchronous assertion between clock edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_valid"}, 64'(m_valid), 64'(0));
    check({tag, "_rst_data"},  64'(m_data),  64'(0));
    check({tag, "_rst_keep"},  64'(m_keep),  64'(0));
    check({tag, "_rst_last"},  64'(m_last),  64'(0));
    check({tag, "_rst_ready"}, 64'(s_ready), 64'(0));
    check({tag, "_rst_pkt"},   64'(pkt_cnt), 64'(0));
    check({tag, "_rst_pad"},   64'(pad_cnt), 64'(0));
    exp_q.delete();
    tb_idx = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    logic [15:0] d1;
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    s1_valid = 1'b0;
    s1_data  = '0;
    m1_ready = 1'b1;
    #7;
    check("init_valid", 64'(m_valid), 64'(0));
    check("init_ready", 64'(s_ready), 64'(0));
    check("init_pkt",   64'(pkt_cnt), 64'(0));
    check("init_pad",   64'(pad_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Continuous 16 beats, always ready.
    popped = 0;
    for (int d = 1; d <= 16; d++) begin
      send(16'(d));
      if (d == 1) begin
        check("t1_lat_valid", 64'(m_valid), 64'(1));
        check("t1_lat_data",  64'(m_data),  64'(1));
      end
    end
    drain();
    check("t1_popped", 64'(popped), 64'(16));
    check("t1_pkt",    64'(pkt_cnt), 64'(2));
    check("t1_pad",    64'(pad_cnt), 64'(0));

    // 3 beats then idle: timeout after 64 idle cycles, 5 pad beats.
    do_reset("t2");
    send(16'h00A1); send(16'h00A2); send(16'h00A3);
    for (int i = 0; i < 5; i++) push(16'h0000, 2'b00);
    wait_cycles(63);
    check("t2_ready_before_pad", 64'(s_ready), 64'(1));
    wait_cycles(1);
    check("t2_ready_in_pad", 64'(s_ready), 64'(0));
    wait_cycles(2);
    check("t2_ready_in_pad2", 64'(s_ready), 64'(0));
    drain();
    check("t2_pad", 64'(pad_cnt), 64'(5));
    check("t2_pkt", 64'(pkt_cnt), 64'(1));
    check("t2_ready_after", 64'(s_ready), 64'(1));

    // Beat arrives exactly as the timer reaches 63: accepted, no padding.
    do_reset("t3");
    send(16'h00B1); send(16'h00B2); send(16'h00B3);
    wait_cycles(63);
    check("t3_ready_edge", 64'(s_ready), 64'(1));
    for (int i = 4; i <= 8; i++) send(16'h00B0 + 16'(i));
    drain();
    wait_cycles(70);
    check("t3_pad",   64'(pad_cnt), 64'(0));
    check("t3_pkt",   64'(pkt_cnt), 64'(1));
    check("t3_valid", 64'(m_valid), 64'(0));

    // Random output backpressure, continuous input.
    do_reset("t4");
    popped = 0;
    rand_mode = 1'b1;
    for (int i = 0; i < 80; i++) send(16'h0100 + 16'(i));
    drain();
    rand_mode = 1'b0;
    wait_cycles(1);
    check("t4_popped", 64'(popped), 64'(80));
    check("t4_pkt",    64'(pkt_cnt), 64'(10));
    check("t4_pad",    64'(pad_cnt), 64'(0));

    // Reset mid-packet, then a full clean packet.
    do_reset("t5a_pre");
    send(16'h0051); send(16'h0052); send(16'h0053); send(16'h0054);
    do_reset("t5a");
    popped = 0;
    for (int i = 1; i <= 8; i++) send(16'h0060 + 16'(i));
    drain();
    check("t5a_popped", 64'(popped), 64'(8));
    check("t5a_pkt",    64'(pkt_cnt), 64'(1));
    check("t5a_pad",    64'(pad_cnt), 64'(0));

    // Reset while padding.
    send(16'h0081); send(16'h0082); send(16'h0083);
    for (int i = 0; i < 5; i++) push(16'h0000, 2'b00);
    wait_cycles(65);
    check("t5b_in_pad", 64'(s_ready), 64'(0));
    do_reset("t5b");
    popped = 0;
    for (int i = 1; i <= 8; i++) send(16'h0070 + 16'(i));
    drain();
    check("t5b_popped", 64'(popped), 64'(8));
    check("t5b_pkt",    64'(pkt_cnt), 64'(1));
    check("t5b_pad",    64'(pad_cnt), 64'(0));

    // PKT_LEN=1, TIMEOUT=0 instance: every beat is tlast, idle never pads.
    for (int k = 0; k < 3; k++) begin
      d1 = 16'h0A0A + 16'(k) * 16'h0101;
      acc = 1'b0;
      s1_valid = 1'b1;
      s1_data  = d1;
      for (int i = 0; i < 100 && !acc; i++) begin
        acc = s1_ready;
        @(posedge clk);
        #1;
      end
      s1_valid = 1'b0;
      check("t6_accept", 64'(acc),      64'(1));
      check("t6_valid",  64'(m1_valid), 64'(1));
      check("t6_data",   64'(m1_data),  64'(d1));
      check("t6_last",   64'(m1_last),  64'(1));
      check("t6_keep",   64'(m1_keep),  64'(2'b11));
    end
    wait_cycles(200);
    check("t6_pkt",   64'(pkt1_cnt), 64'(3));
    check("t6_pad",   64'(pad1_cnt), 64'(0));
    check("t6_idle",  64'(m1_valid), 64'(0));
    check("t6_ready", 64'(s1_ready), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_pkt_framer.md
Name: axis_pkt_framer

Overview:
- Sits directly downstream of a BRAM-backed AXI4-Stream queue output, which carries bare data beats with no tlast or tkeep.
- Groups beats into fixed-length packets of PKT_LEN beats and drives tlast on the final beat.
- If the input stalls mid-packet for TIMEOUT cycles, the partial packet is closed with null pad beats, so the consumer never waits indefinitely on a half-built packet.
- Exposes packet and pad counters for status readout through the kernel's control interface.

Parameters:
- DWIDTH, 16, data width in bits; must be a multiple of 8.
- PKT_LEN, 8, beats per packet; must be 1 or more.
- TIMEOUT, 64, idle cycles mid-packet before padding starts; 0 disables padding.
- CNT_WIDTH, 32, width of the status counters.

Ports:
- ap_clk  in  1  single clock; all logic on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- s_din_tvalid  in  1  input beat valid.
- s_din_tready  out  1  input beat ready.
- s_din_tdata  in  DWIDTH  input beat data.
- m_dout_tvalid  out  1  output beat valid.
- m_dout_tready  in  1  output beat ready.
- m_dout_tdata  out  DWIDTH  output data.
- m_dout_tkeep  out  DWIDTH/8  all ones for data beats, all zeros for pad beats.
- m_dout_tlast  out  1  high on beat PKT_LEN-1 of every packet.
- pkt_count  out  CNT_WIDTH  packets completed on the output (tlast handshakes).
- pad_count  out  CNT_WIDTH  pad beats emitted.

Behaviour:
- Reset: one clock (ap_clk); reset is asynchronous and active-low (ap_rst_n).
  - Assertion immediately clears state, beat index, timer, skid buffer and counters.
  - While in reset: m_dout_tvalid=0, m_dout_tdata=0, m_dout_tkeep=0, m_dout_tlast=0, s_din_tready=0, pkt_count=0, pad_count=0.
  - A partial packet in flight at reset is discarded; the first packet after reset starts at beat 0.
- Output stage:
  - 2-entry skid buffer; all m_dout_* driven from registers.
  - Latency from input handshake to m_dout_tvalid is 1 cycle.
  - Sustains 1 beat/cycle under continuous tready.
  - s_din_tready is high only when state != PAD and the skid buffer is not full.
  - m_dout_* stay stable while tvalid=1 and tready=0.
- beat_idx: 0..PKT_LEN-1, advanced on every beat written into the skid buffer (data or pad). tlast = (beat_idx == PKT_LEN-1); beat_idx then wraps to 0.
- States:
  - IDLE: beat_idx=0, timer held at 0. An accepted beat goes to FILL, or stays in IDLE if PKT_LEN=1.
  - FILL: 0 < beat_idx < PKT_LEN.
    - An accepted beat clears the timer; if it is the last beat, go to IDLE.
    - A cycle with no accept increments the timer. When timer == TIMEOUT-1 and no accept this cycle, go to PAD. Not possible if TIMEOUT=0.
    - Simultaneous input accept and timeout expiry: the accept wins, the timer clears and the state stays FILL.
  - PAD:
    - Input blocked.
    - Writes pad beats (tdata=0, tkeep=0) whenever the skid buffer has space, until the beat with tlast; then go to IDLE.
    - pad_count increments per pad beat written.
- Timer width is clog2(TIMEOUT+1). The timer does not run while the skid buffer is full (output backpressure is not an input stall).
- pkt_count increments on each m_dout handshake with tlast=1.
- Both counters wrap modulo 2^CNT_WIDTH.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, FILL=2'd1, PAD=2'd2;
  - the clog2 function;
  - the tkeep-all-ones and tkeep-null constants (functions of DWIDTH).
- One sub-module, axis_skid_buffer (parameter DWIDTH+DWIDTH/8+1 payload bits), is reusable across other kernel stages.
- The framer FSM, timer and counters live in the top.

Test Plan:
- Continuous 16 beats, data 0x0001..0x0010, tready=1, PKT_LEN=8 → 16 output beats with 1-cycle latency; tlast on 0x0008 and 0x0010; tkeep=2'b11; pkt_count=2, pad_count=0.
- 3 beats, then input idle, TIMEOUT=64 → after 64 idle cycles, 5 pad beats (tdata=0, tkeep=0), tlast on the 5th; s_din_tready=0 during PAD; pad_count=5, pkt_count=1.
- Beat arrives in the exact cycle the timer hits 63 → accepted as data, no padding; the packet completes normally.
- Random tready (50%) with continuous input, 80 beats → output equals input in order; 10 tlasts; no tvalid drop or data change under stall; the timer never expires.
- ap_rst_n asserted mid-packet (beat 4) and in PAD, asynchronous to the clock edge → outputs clear immediately; the next packet starts at beat 0 with 8 full beats; counters restart at 0.
- PKT_LEN=1, TIMEOUT=0 → every beat has tlast=1; a 200-cycle idle period produces no pad beats.
